// File: rtl/led_pattern_ctrl.sv
// Switch-to-LED pattern controller: static/blink/chase/scroll patterns with a
// debounced push-button that toggles a global output invert.

module led_pattern_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic pat,
  input  logic inv,
  output logic led
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= pat ^ inv;
  end
endmodule

module led_pattern_ctrl #(
  parameter int N_LED        = 10,
  parameter int DEBOUNCE_CYC = 16,
  parameter int STEP_DIV     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] sw,
  input  logic             btn,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             inv
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int ST_W  = $clog2(STEP_DIV);
  localparam int POS_W = $clog2(N_LED);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);

  typedef enum logic [1:0] {M_STATIC, M_BLINK, M_CHASE, M_SCROLL} mode_e;

  // button: synchroniser, debounce, press-edge invert toggle
  logic [1:0]      btn_sync;
  logic            btn_s, btn_db;
  logic [DB_W-1:0] db_cnt;

  assign btn_s = btn_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      btn_db   <= 1'b0;
      db_cnt   <= '0;
      inv      <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], btn};
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_db <= btn_s;
        db_cnt <= '0;
        if (btn_s) inv <= ~inv;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // pattern state
  mode_e            mode_q, nxt_mode, mode_in;
  logic [ST_W-1:0]  step_cnt, nxt_step;
  logic             phase, nxt_phase, step;
  logic [POS_W-1:0] pos, nxt_pos;
  logic [N_LED-1:0] scroll, nxt_scroll, pat;

  assign mode_in = mode_e'(mode);
  assign step    = (step_cnt == ST_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= M_STATIC;
      step_cnt <= '0;
      phase    <= 1'b0;
      pos      <= '0;
      scroll   <= '0;
    end else begin
      mode_q   <= nxt_mode;
      step_cnt <= nxt_step;
      phase    <= nxt_phase;
      pos      <= nxt_pos;
      scroll   <= nxt_scroll;
    end
  end

  // a mode change restarts the pattern and suppresses any step that cycle
  always_comb begin
    nxt_mode   = mode_q;
    nxt_step   = step_cnt;
    nxt_phase  = phase;
    nxt_pos    = pos;
    nxt_scroll = scroll;
    if (mode_in != mode_q) begin
      nxt_mode   = mode_in;
      nxt_step   = '0;
      nxt_phase  = 1'b0;
      nxt_pos    = '0;
      nxt_scroll = sw;
    end else begin
      nxt_step = step ? '0 : step_cnt + 1'b1;
      if (step) begin
        case (mode_q)
          M_BLINK:  nxt_phase  = ~phase;
          M_CHASE:  nxt_pos    = (pos == POS_MAX) ? '0 : pos + 1'b1;
          M_SCROLL: nxt_scroll = {scroll[N_LED-2:0], scroll[N_LED-1]};
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    pat = sw;
    case (mode_q)
      M_BLINK:  pat = phase ? '0 : sw;
      M_CHASE:  pat = N_LED'(1) << pos;
      M_SCROLL: pat = scroll;
      default:  pat = sw;
    endcase
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_lane
    led_pattern_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .pat   (pat[i]),
      .inv   (inv),
      .led   (led[i])
    );
  end
endmodule
